// File: rtl/cordic_ctrl_pkg.sv
// Shared types and constants for the CORDIC command sequencer: phase encoding,
// latched-command layout, function-code rules and Q2.14 reference values.
package cordic_ctrl_pkg;

  localparam int FUNC_W   = 4;
  localparam int DATA_W   = 16;
  localparam int MAX_FUNC = 8;

  // Function codes that carry a second operand; every other legal code skips OP2.
  localparam logic [FUNC_W-1:0] FN_TWO_OP_0 = 4'd0;
  localparam logic [FUNC_W-1:0] FN_TWO_OP_1 = 4'd1;
  localparam logic [FUNC_W-1:0] FN_TWO_OP_7 = 4'd7;

  localparam logic [DATA_W-1:0] ONE  = 16'h4000;
  localparam logic [DATA_W-1:0] HALF = 16'h2000;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FUNC   = 3'd1,
    ST_OP1    = 3'd2,
    ST_OP2    = 3'd3,
    ST_GO     = 3'd4,
    ST_RESULT = 3'd5
  } state_t;

  typedef struct packed {
    logic [FUNC_W-1:0] func;
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
  } cmd_t;

  function automatic logic is_two_op(input logic [FUNC_W-1:0] func);
    return (func == FN_TWO_OP_0) || (func == FN_TWO_OP_1) || (func == FN_TWO_OP_7);
  endfunction

endpackage

// File: rtl/cordic_cmd_sequencer_if.sv
// Command request channel into the sequencer; valid/ready handshake, the source
// holds func/op1/op2 stable until ready is seen.
interface cordic_cmd_sequencer_if;
  import cordic_ctrl_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [FUNC_W-1:0] req_func;
  logic [DATA_W-1:0] req_op1;
  logic [DATA_W-1:0] req_op2;

  modport master (
    output req_valid,
    output req_func,
    output req_op1,
    output req_op2,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_func,
    input  req_op1,
    input  req_op2,
    output req_ready
  );

endinterface

// File: rtl/cordic_cmd_sequencer_phase_timer.sv
// Phase length counter: cleared on phase entry, counts up each cycle, expire is
// combinational when the count reaches the supplied limit; no backpressure.
module phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [CNT_W-1:0] limit,
  output logic             expire
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expire = (cnt_q == limit);

endmodule

// File: rtl/cordic_cmd_sequencer.sv
// Steps one command through FUNC/OP1/[OP2]/GO/RESULT on the CORDIC st/sw_in pins;
// done lands 3 or 4 x (HOLD_CYCLES+1) + RESULT_CYCLES + 2 after accept; ready only in IDLE.
module cordic_cmd_sequencer
  import cordic_ctrl_pkg::*;
#(
  parameter int HOLD_CYCLES   = 70,
  parameter int RESULT_CYCLES = 70,
  parameter int CNT_W         = 8,
  parameter int MAX_FUNC      = cordic_ctrl_pkg::MAX_FUNC
) (
  input  logic                   clk,
  input  logic                   reset,
  cordic_cmd_sequencer_if.slave  req,
  output logic                   st,
  output logic [DATA_W-1:0]      sw_in,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  state_t            state_q, state_d;
  cmd_t              cmd_q;
  logic [DATA_W-1:0] sw_q, sw_d;
  logic              done_q, err_q;
  logic              accept, legal, expire, phase_end;
  logic [CNT_W-1:0]  limit;

  assign req.req_ready = (state_q == ST_IDLE);
  assign accept        = req.req_valid && req.req_ready;
  assign legal         = (int'(req.req_func) <= MAX_FUNC);

  assign limit     = (state_q == ST_RESULT) ? CNT_W'(RESULT_CYCLES) : CNT_W'(HOLD_CYCLES);
  assign phase_end = (state_q != ST_IDLE) && expire;

  // Held clear in IDLE so every phase starts counting from zero on entry.
  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  ((state_q == ST_IDLE) || phase_end),
    .limit  (limit),
    .expire (expire)
  );

  always_comb begin
    state_d = state_q;
    sw_d    = sw_q;
    case (state_q)
      ST_IDLE: begin
        if (accept && legal) begin
          state_d = ST_FUNC;
          sw_d    = {{(DATA_W-FUNC_W){1'b0}}, req.req_func};
        end
      end
      ST_FUNC: begin
        if (phase_end) begin
          state_d = ST_OP1;
          sw_d    = cmd_q.op1;
        end
      end
      ST_OP1: begin
        if (phase_end) begin
          if (is_two_op(cmd_q.func)) begin
            state_d = ST_OP2;
            sw_d    = cmd_q.op2;
          end else begin
            state_d = ST_GO;
            sw_d    = '0;
          end
        end
      end
      ST_OP2: begin
        if (phase_end) begin
          state_d = ST_GO;
          sw_d    = '0;
        end
      end
      ST_GO: begin
        if (phase_end) begin
          state_d = ST_RESULT;
          sw_d    = '0;
        end
      end
      ST_RESULT: begin
        if (phase_end) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        sw_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      sw_q    <= '0;
      cmd_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sw_q    <= sw_d;
      done_q  <= (state_q == ST_RESULT) && phase_end;
      err_q   <= accept && !legal;
      if (accept && legal) begin
        cmd_q <= '{func: req.req_func, op1: req.req_op1, op2: req.req_op2};
      end
    end
  end

  assign st    = phase_end;
  assign sw_in = sw_q;
  assign busy  = (state_q != ST_IDLE);
  assign done  = done_q;
  assign err   = err_q;

endmodule

// File: tb/tb_cordic_cmd_sequencer.sv
// Randomized bench for cordic_cmd_sequencer: a phase-level trace model predicts
// every cycle's ready/busy/st/done/err/sw_in after each accepted command.
module tb_cordic_cmd_sequencer;
  import cordic_ctrl_pkg::*;

  localparam int H = 3;
  localparam int R = 5;

  typedef struct packed {
    logic        rdy;
    logic        busy;
    logic        st;
    logic        done;
    logic        err;
    logic [15:0] sw;
  } obs_t;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic        st;
  logic [15:0] sw_in;
  logic        busy, done, err;

  int          checks   = 0;
  int          failures = 0;
  obs_t        exp_q[$];
  logic [15:0] last_sw  = 16'h0;

  cordic_cmd_sequencer_if req_if();

  cordic_cmd_sequencer #(
    .HOLD_CYCLES  (H),
    .RESULT_CYCLES(R),
    .CNT_W        (8),
    .MAX_FUNC     (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req_if),
    .st    (st),
    .sw_in (sw_in),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  always #5 clk = ~clk;

  function automatic obs_t observe();
    return {req_if.req_ready, busy, st, done, err, sw_in};
  endfunction

  // Expected per-cycle trace of one command, starting the cycle after acceptance.
  function automatic void model_cmd(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] vals[$];
    if (f > 4'd8) begin
      exp_q.push_back({1'b1, 1'b0, 1'b0, 1'b0, 1'b1, last_sw});
      return;
    end
    vals.push_back({12'h0, f});
    vals.push_back(a);
    if (f == 4'd0 || f == 4'd1 || f == 4'd7) vals.push_back(b);
    vals.push_back(16'h0);
    foreach (vals[p])
      for (int i = 0; i <= H; i++) exp_q.push_back({2'b01, (i == H), 2'b00, vals[p]});
    for (int i = 0; i <= R; i++) exp_q.push_back({2'b01, (i == R), 2'b00, 16'h0});
    exp_q.push_back({1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0});
    last_sw = 16'h0;
  endfunction

  function automatic void model_idle(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, last_sw});
  endfunction

  task automatic issue(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b, input bit hold);
    @(negedge clk);
    req_if.req_func  = f;
    req_if.req_op1   = a;
    req_if.req_op2   = b;
    req_if.req_valid = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) req_if.req_valid = 1'b0;
  endtask

  task automatic test_reset();
    obs_t o;
    req_if.req_valid = 1'b0;
    req_if.req_func  = 4'h0;
    req_if.req_op1   = 16'h0;
    req_if.req_op2   = 16'h0;
    #2 reset = 1'b1;
    #1;
    o = observe();
    checks++;
    if (o !== obs_t'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0})) begin
      failures++;
      $display("FAIL reset_async got=%h exp=%h", o, obs_t'({1'b1, 5'b0, 15'h0}));
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    model_idle(3);
    for (int k = 1; exp_q.size() > 0; k++) begin
      obs_t e;
      @(negedge clk);
      e = exp_q.pop_front();
      o = observe();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL reset_idle cyc=%0d got=%h exp=%h", k, o, e);
      end
    end
  endtask

  task automatic test_two_op();
    obs_t o, e;
    model_cmd(4'd1, ONE, HALF);
    model_idle(3);
    issue(4'd1, ONE, HALF, 1'b0);
    for (int k = 1; exp_q.size() > 0; k++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      o = observe();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL two_op cyc=%0d got=%h exp=%h", k, o, e);
      end
    end
  endtask

  task automatic test_one_op();
    obs_t o, e;
    model_cmd(4'd3, HALF, 16'h1234);
    model_idle(3);
    issue(4'd3, HALF, 16'h1234, 1'b0);
    for (int k = 1; exp_q.size() > 0; k++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      o = observe();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL one_op cyc=%0d got=%h exp=%h", k, o, e);
      end
      checks++;
      if (sw_in === req_if.req_op2) begin
        failures++;
        $display("FAIL one_op_no_op2 cyc=%0d got=%h must_differ_from=%h", k, sw_in, req_if.req_op2);
      end
    end
  endtask

  task automatic test_illegal();
    obs_t o, e;
    logic [3:0] codes[2];
    codes[0] = 4'd9;
    codes[1] = 4'd15;
    foreach (codes[c]) begin
      model_cmd(codes[c], 16'hBEEF, 16'hCAFE);
      model_idle(4);
      issue(codes[c], 16'hBEEF, 16'hCAFE, 1'b0);
      for (int k = 1; exp_q.size() > 0; k++) begin
        @(negedge clk);
        e = exp_q.pop_front();
        o = observe();
        checks++;
        if (o !== e) begin
          failures++;
          $display("FAIL illegal_func f=%0d cyc=%0d got=%h exp=%h", codes[c], k, o, e);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    obs_t o, e;
    int len1;
    logic [15:0] a1, b1, a2, b2;
    a1 = 16'($urandom); b1 = 16'($urandom);
    a2 = 16'($urandom); b2 = 16'($urandom);
    model_cmd(4'd0, a1, b1);
    len1 = exp_q.size();
    model_cmd(4'd7, a2, b2);
    model_idle(3);
    issue(4'd0, a1, b1, 1'b1);
    req_if.req_func = 4'd7;
    req_if.req_op1  = a2;
    req_if.req_op2  = b2;
    for (int k = 1; exp_q.size() > 0; k++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      o = observe();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL back_to_back cyc=%0d got=%h exp=%h", k, o, e);
      end
      if (k > len1) req_if.req_valid = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    obs_t o, e;
    logic [15:0] a, b;
    a = 16'($urandom) | 16'h0100;
    b = 16'($urandom) | 16'h0001;
    model_cmd(4'd0, a, b);
    issue(4'd0, a, b, 1'b0);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      o = observe();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL reset_mid_pre cyc=%0d got=%h exp=%h", k, o, e);
      end
    end
    exp_q.delete();
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    o = observe();
    checks++;
    if (o !== obs_t'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0})) begin
      failures++;
      $display("FAIL reset_mid_async got=%h exp=%h", o, obs_t'({1'b1, 20'h0}));
    end
    repeat (2) @(negedge clk);
    reset   = 1'b0;
    last_sw = 16'h0;
    model_idle(25);
    for (int k = 1; exp_q.size() > 0; k++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      o = observe();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL reset_mid_after cyc=%0d got=%h exp=%h", k, o, e);
      end
    end
  endtask

  task automatic test_disturb();
    obs_t o, e;
    logic [15:0] a, b;
    a = 16'($urandom);
    b = 16'($urandom);
    model_cmd(4'd7, a, b);
    model_idle(6);
    issue(4'd7, a, b, 1'b0);
    for (int k = 1; exp_q.size() > 0; k++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      o = observe();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL disturb cyc=%0d got=%h exp=%h", k, o, e);
      end
      if (k < 20) begin
        req_if.req_func  = 4'($urandom_range(0, 8));
        req_if.req_op1   = 16'($urandom);
        req_if.req_op2   = 16'($urandom);
        req_if.req_valid = 1'($urandom);
      end else begin
        req_if.req_valid = 1'b0;
      end
    end
  endtask

  task automatic test_random();
    obs_t o, e;
    logic [3:0]  f;
    logic [15:0] a, b;
    for (int n = 0; n < 8; n++) begin
      f = 4'($urandom_range(0, 11));
      a = 16'($urandom);
      b = 16'($urandom);
      model_cmd(f, a, b);
      model_idle($urandom_range(1, 3));
      issue(f, a, b, 1'b0);
      for (int k = 1; exp_q.size() > 0; k++) begin
        @(negedge clk);
        e = exp_q.pop_front();
        o = observe();
        checks++;
        if (o !== e) begin
          failures++;
          $display("FAIL random n=%0d f=%0d cyc=%0d got=%h exp=%h", n, f, k, o, e);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_two_op();
    test_one_op();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    test_disturb();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
